// File: rtl/dm_access_ctrl.sv
// Multi-cycle data-memory access controller: MEM-stage request -> handshaked bus, with load extension and timeout abort.
// Optional misalignment exceptions are enabled by defining DM_ALIGN_EXC_EN.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_type,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before abort: the TIMEOUT-th BUS cycle without ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic        accept_s, misalign_s, timeout_s;
    logic        stall_s, bus_req_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    logic        we_r, uns_r;
    logic [1:0]  type_r, lane_r;
    logic [7:0]  cnt_r;
    logic [31:0] bus_addr_r, bus_wdata_r, ld_data_r;
    logic [3:0]  bus_be_r;
    logic        ld_valid_r, exc_adel_r, exc_ades_r, bus_err_r;

    function automatic logic [31:0] extract_load(input logic [1:0] t, input logic u,
                                                 input logic [1:0] lane, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lane, 3'b000} +: 8];
        h = d[{lane[1], 4'b0000} +: 16];
        case (t)
            2'b01:   r = u ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b10:   r = u ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request decode: acceptance, alignment, byte enables and lane-replicated store data.
    always_comb begin
        accept_s = req_valid && (req_type != 2'b00);
`ifdef DM_ALIGN_EXC_EN
        misalign_s = ((req_type == 2'b10) && req_addr[0]) ||
                     ((req_type == 2'b11) && (req_addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        case (req_type)
            2'b01: begin
                be_s    = 4'b0001 << req_addr[1:0];
                wdata_s = {4{req_wdata[7:0]}};
            end
            2'b10: begin
                be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{req_wdata[15:0]}};
            end
            2'b11: begin
                be_s    = 4'b1111;
                wdata_s = req_wdata;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
        timeout_s = (state_r == BUS) && !bus_ack && (cnt_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an ack in the final timeout cycle still completes normally.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = misalign_s ? DONE : BUS;
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                if (bus_ack || timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUS;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs; stall is combinational in IDLE so the requester is held in the accept cycle.
    always_comb begin
        stall_s   = 1'b0;
        bus_req_s = 1'b0;
        case (state_r)
            IDLE: stall_s = accept_s;
            BUS: begin
                stall_s   = 1'b1;
                bus_req_s = 1'b1;
            end
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Request latch, timeout counter, load capture and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r        <= 1'b0;
            uns_r       <= 1'b0;
            type_r      <= 2'b00;
            lane_r      <= 2'b00;
            cnt_r       <= 8'd0;
            bus_addr_r  <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            ld_data_r   <= 32'h0000_0000;
            ld_valid_r  <= 1'b0;
            exc_adel_r  <= 1'b0;
            exc_ades_r  <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            ld_valid_r <= 1'b0;
            exc_adel_r <= 1'b0;
            exc_ades_r <= 1'b0;
            bus_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r        <= req_we;
                        uns_r       <= req_unsigned;
                        type_r      <= req_type;
                        lane_r      <= req_addr[1:0];
                        cnt_r       <= 8'd0;
                        bus_addr_r  <= {req_addr[31:2], 2'b00};
                        bus_be_r    <= be_s;
                        bus_wdata_r <= wdata_s;
                        exc_adel_r  <= misalign_s && !req_we;
                        exc_ades_r  <= misalign_s && req_we;
                    end
                end
                BUS: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (bus_ack) begin
                        if (!we_r) begin
                            ld_data_r  <= extract_load(type_r, uns_r, lane_r, bus_rdata);
                            ld_valid_r <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        ld_data_r <= 32'h0000_0000;
                        bus_err_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign bus_req   = bus_req_s;
    assign bus_we    = we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;
    assign ld_data   = ld_data_r;
    assign ld_valid  = ld_valid_r;
    assign exc_adel  = exc_adel_r;
    assign exc_ades  = exc_ades_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl (TIMEOUT=4): expected bus beats and completion pulses are queued by the driver and popped by monitors.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        stall, ld_valid, exc_adel, exc_ades, bus_err;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct {
        logic [3:0]  flags;   // {ld_valid, exc_adel, exc_ades, bus_err}
        logic [31:0] data;
        logic        chk;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    res_t  res_q[$];
    beat_t bus_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_type(req_type), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_res(input logic [3:0] f, input logic [31:0] d, input logic c);
        res_t r;
        r.flags = f; r.data = d; r.chk = c;
        res_q.push_back(r);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    // Completion-pulse monitor.
    always @(negedge clk) begin
        if (!reset && (ld_valid || exc_adel || exc_ades || bus_err)) begin
            if (res_q.size() == 0) begin
                check("unexpected_pulse", {60'h0, ld_valid, exc_adel, exc_ades, bus_err}, 64'h0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("pulse_flags", {60'h0, ld_valid, exc_adel, exc_ades, bus_err}, {60'h0, r.flags});
                if (r.chk) check("ld_data", {32'h0, ld_data}, {32'h0, r.data});
            end
        end
    end

    // Bus-beat monitor.
    always @(negedge clk) begin
        if (!reset && bus_req && bus_ack) begin
            if (bus_q.size() == 0) begin
                check("unexpected_beat", {63'h0, bus_ack}, 64'h0);
            end else begin
                beat_t b;
                b = bus_q.pop_front();
                check("bus_addr", {32'h0, bus_addr}, {32'h0, b.addr});
                check("bus_be_we", {59'h0, bus_be, bus_we}, {59'h0, b.be, b.we});
                check("bus_wdata", {32'h0, bus_wdata}, {32'h0, b.wdata});
            end
        end
    end

    task automatic access(input logic we, input logic [1:0] typ, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input bit noack, input logic [31:0] rdata,
                          input int exp_stall, input int exp_breq);
        int k, n_stall, n_breq;
        bit done;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_type = typ; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; bus_ack = 1'b0;
        k = 0; n_stall = 0; n_breq = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (bus_req) n_breq++;
            done = !stall;
            @(posedge clk); #1;
            if (done) begin
                req_valid = 1'b0;
                bus_ack   = 1'b0;
            end else if (bus_req) begin
                bus_ack   = !noack && (k == waits);
                bus_rdata = rdata;
                k++;
            end else begin
                bus_ack = 1'b0;
            end
        end
        check("access_done", {63'h0, done}, 64'h1);
        check("stall_cycles", 64'(n_stall), 64'(exp_stall));
        check("bus_req_cycles", 64'(n_breq), 64'(exp_breq));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", {stall, ld_valid, exc_adel, exc_ades, bus_err, bus_req, bus_we, bus_be, 1'b0},
              64'h0);
        check("reset_data", {ld_data, bus_addr}, 64'h0);
        check("reset_wdata", {32'h0, bus_wdata}, 64'h0);

        // Word load, ack in first BUS cycle.
        push_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        push_res(4'b1000, 32'hDEADBEEF, 1'b1);
        access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'hDEADBEEF, 2, 1);

        // Signed/unsigned byte loads, lane 3, ack on the 4th BUS cycle (last cycle before timeout).
        push_bus(32'h200, 4'b1000, 1'b0, 32'h0);
        push_res(4'b1000, 32'hFFFFFF80, 1'b1);
        access(1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 3, 1'b0, 32'h80112233, 5, 4);
        push_bus(32'h200, 4'b1000, 1'b0, 32'h0);
        push_res(4'b1000, 32'h00000080, 1'b1);
        access(1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 3, 1'b0, 32'h80112233, 5, 4);

        // Half store: no load pulse, ld_data holds.
        push_bus(32'h300, 4'b1100, 1'b1, 32'hABCDABCD);
        access(1'b1, 2'b10, 1'b0, 32'h302, 32'h0000ABCD, 1, 1'b0, 32'h0, 3, 2);
        check("ld_data_hold", {32'h0, ld_data}, 64'h80);

        // Byte store, lane 1.
        push_bus(32'h000, 4'b0010, 1'b1, 32'h5A5A5A5A);
        access(1'b1, 2'b01, 1'b0, 32'h001, 32'h0000005A, 2, 1'b0, 32'h0, 4, 3);

        // Signed half load, upper lane.
        push_bus(32'h100, 4'b1100, 1'b0, 32'h0);
        push_res(4'b1000, 32'hFFFF8001, 1'b1);
        access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1'b0, 32'h80017FFF, 2, 1);

        // Misaligned word load and half store.
`ifdef DM_ALIGN_EXC_EN
        push_res(4'b0100, 32'h0, 1'b0);
        access(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 0, 1'b0, 32'h12345678, 1, 0);
        push_res(4'b0010, 32'h0, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h301, 32'h00001234, 0, 1'b0, 32'h0, 1, 0);
`else
        push_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        push_res(4'b1000, 32'h12345678, 1'b1);
        access(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 0, 1'b0, 32'h12345678, 2, 1);
        push_bus(32'h300, 4'b0011, 1'b1, 32'h12341234);
        access(1'b1, 2'b10, 1'b0, 32'h301, 32'h00001234, 0, 1'b0, 32'h0, 2, 1);
`endif

        // Timeout: bus_req for exactly 4 cycles, bus_err, ld_data cleared.
        push_res(4'b0001, 32'h0, 1'b1);
        access(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'h0, 5, 4);

        // Unsigned byte load lane 0 after the abort.
        push_bus(32'h000, 4'b0001, 1'b0, 32'h0);
        push_res(4'b1000, 32'h000000FF, 1'b1);
        access(1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 1, 1'b0, 32'h7F7F80FF, 3, 2);

        // req_type=00 is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_type = 2'b00; req_addr = 32'h600;
        @(negedge clk);
        check("type00_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("type00_bus_req", {62'h0, bus_req, stall}, 64'h0);

        // Reset during BUS: request dropped, no pulse.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_type = 2'b11; req_addr = 32'h500; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_bus_req", {63'h0, bus_req}, 64'h1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_bus_req", {62'h0, bus_req, stall}, 64'h0);
        check("reset_ld_data", {32'h0, ld_data}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_reset", {62'h0, bus_req, stall}, 64'h0);

        check("res_q_drained", 64'(res_q.size()), 64'h0);
        check("bus_q_drained", 64'(bus_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multi-cycle data-memory access controller between the MEM stage and a handshaked data-memory bus. It accepts one load or store per request, builds word-aligned bus address, byte enables and lane-replicated write data, and holds the pipeline stalled until the bus acknowledges. It returns sign- or zero-extended load data, detects misaligned accesses, and aborts bus transactions that exceed a timeout.

## Interface
- TIMEOUT, 255: max BUS-state cycles waiting for bus_ack before abort; range 1..255
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage presents an access this cycle
- req_we  in  1  1 = store, 0 = load
- req_type  in  2  01 byte, 10 halfword, 11 word; 00 = no access
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold MEM and earlier stages
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- exc_adel / exc_ades  out  1  one-cycle pulse, misaligned load / store
- bus_err  out  1  one-cycle pulse, timeout abort
- bus_req  out  1  bus request, held until ack or abort
- bus_we  out  1  bus write
- bus_addr  out  32  {req_addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transfer complete this cycle
- bus_rdata  in  32  read data, valid when bus_ack=1

## Operation
- States: IDLE, BUS, DONE.
- IDLE: if req_valid and req_type!=00, latch request. Aligned -> BUS. Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with exc flag set, no bus traffic. req_type=00 ignored.
- BUS: bus_req=1, bus_we/addr/be/wdata stable from registers. On bus_ack: load -> capture extended bus_rdata into ld_data; go DONE. Timeout counter increments each BUS cycle without ack; when it reaches TIMEOUT -> DONE with error flag, ld_data=0.
- DONE: stall=0; pulse ld_valid (successful load only), exc_adel/exc_ades, or bus_err. req_valid is ignored in DONE (it is the completing instruction). -> IDLE.
- Byte enables: byte -> 1<<addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
- Write data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
- Load extract: byte lane addr[1:0] (bits 8k+7:8k); half lane addr[1] (bits 16h+15:16h); extend to 32 bits per req_unsigned; word passes through.
- stall = (IDLE & req_valid & req_type!=00) | BUS. Combinational in IDLE so the requesting instruction is held in the acceptance cycle.

## Timing
- Reset: state IDLE; stall, ld_valid, exc_adel, exc_ades, bus_err, bus_req, bus_we = 0; bus_be = 0; ld_data, bus_addr, bus_wdata = 0; timeout counter = 0.
- Reset in BUS: bus_req low after that edge; request discarded, no pulse.
- Minimum access: accept in cycle 0, bus_req cycle 1, ack cycle 1, DONE cycle 2. stall high cycles 0-1; ld_valid high cycle 2.
- Ack after n wait cycles: stall high n+2 cycles.
- Misaligned: stall high cycle 0 only; exception pulse cycle 1; bus_req never asserted.
- Timeout: bus_req high exactly TIMEOUT cycles, then DONE with bus_err pulse. A bus_ack arriving in the same cycle the count reaches TIMEOUT wins: normal completion, no bus_err.
- ld_data holds its value until the next successful load completes or reset.

## Configuration
- DM_ALIGN_EXC_EN defined: misalignment is checked as above and raises exc_adel/exc_ades.
- DM_ALIGN_EXC_EN undefined: no misalignment check and exception outputs tied 0. Misaligned halfwords use lane addr[1]; misaligned words use the containing word with be=1111.

## Test plan
- Word load at 0x100, bus_ack in first BUS cycle, rdata 0xDEADBEEF -> stall 2 cycles, ld_valid cycle 2, ld_data 0xDEADBEEF, bus_addr 0x100, be 1111.
- Byte load signed at 0x203, rdata 0x80112233, 3 wait cycles -> be 1000, ld_data 0xFFFFFF80, stall 5 cycles; repeat with req_unsigned=1 -> 0x00000080.
- Half store at 0x302, wdata 0x0000ABCD -> bus_addr 0x300, be 1100, bus_wdata 0xABCDABCD, bus_we=1, no ld_valid.
- Word load at 0x101 with DM_ALIGN_EXC_EN -> exc_adel pulse cycle 1, bus_req never high; without macro -> bus_addr 0x100, normal load.
- TIMEOUT=4, no ack -> bus_req high 4 cycles, bus_err pulse, ld_data 0, stall released; reset asserted mid-BUS -> bus_req 0 next cycle, no pulses.
